// File: rtl/axis_flit_deserializer.sv
// Reassembles SERIALIZATION_FACTOR narrow NoC flits into one AXI-stream beat,
// with sticky framing-error flags and recovery that resynchronises on the next tail flit.
module axis_flit_deserializer #(
    parameter int TDATA_WIDTH          = 32,
    parameter int TDEST_WIDTH          = 4,
    parameter int SERIALIZATION_FACTOR = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flit_in_tvalid,
    output logic                                   flit_in_tready,
    input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] flit_in_tdata,
    input  logic [TDEST_WIDTH-1:0]                 flit_in_tdest,
    input  logic                                   flit_in_tlast,
    input  logic                                   flit_in_ttail,
    output logic                                   axis_out_tvalid,
    input  logic                                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0]                 axis_out_tdata,
    output logic [TDEST_WIDTH-1:0]                 axis_out_tdest,
    output logic                                   axis_out_tlast,
    output logic [2:0]                             err_status
);

    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

    typedef enum logic {ASSEMBLE, RESYNC} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TDATA_WIDTH-1:0]   asm_q, asm_d;
    logic [TDEST_WIDTH-1:0]   capDest_q, capDest_d;
    logic                     capLast_q, capLast_d;
    logic                     outValid_q, outValid_d;
    logic [TDATA_WIDTH-1:0]   outData_q, outData_d;
    logic [TDEST_WIDTH-1:0]   outDest_q, outDest_d;
    logic                     outLast_q, outLast_d;
    logic [2:0]               err_q, err_d;
    logic                     lastIdx;
    logic                     flitAccept;

    assign lastIdx        = (idx_q == LAST_IDX);
    // Only the completing flit needs the output register free (or draining this cycle).
    assign flit_in_tready = (state_q == RESYNC) || !lastIdx || !outValid_q || axis_out_tready;
    assign flitAccept     = flit_in_tvalid && flit_in_tready;

    assign axis_out_tvalid = outValid_q;
    assign axis_out_tdata  = outData_q;
    assign axis_out_tdest  = outDest_q;
    assign axis_out_tlast  = outLast_q;
    assign err_status      = err_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        capDest_d  = capDest_q;
        capLast_d  = capLast_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outDest_d  = outDest_q;
        outLast_d  = outLast_q;
        err_d      = err_q;

        if (outValid_q && axis_out_tready) begin
            outValid_d = 1'b0;
        end

        if (flitAccept) begin
            if (state_q == RESYNC) begin
                if (flit_in_ttail) begin
                    state_d = ASSEMBLE;
                    idx_d   = '0;
                end
            end else begin
                for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        asm_d[k*FLIT_WIDTH +: FLIT_WIDTH] = flit_in_tdata;
                    end
                end

                if (idx_q == '0) begin
                    capDest_d = flit_in_tdest;
                    capLast_d = flit_in_tlast;
                end else if ((flit_in_tdest != capDest_q) || (flit_in_tlast != capLast_q)) begin
                    err_d[2] = 1'b1;
                end

                // err_status bit order is {dest, long, short}.
                if (lastIdx) begin
                    idx_d = '0;
                    if (flit_in_ttail) begin
                        outValid_d = 1'b1;
                        outData_d  = asm_d;
                        outDest_d  = capDest_d;
                        outLast_d  = capLast_d;
                    end else begin
                        err_d[1] = 1'b1;
                        state_d  = RESYNC;
                    end
                end else if (flit_in_ttail) begin
                    err_d[0] = 1'b1;
                    idx_d    = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ASSEMBLE;
            idx_q      <= '0;
            asm_q      <= '0;
            capDest_q  <= '0;
            capLast_q  <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outDest_q  <= '0;
            outLast_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            capDest_q  <= capDest_d;
            capLast_q  <= capLast_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outDest_q  <= outDest_d;
            outLast_q  <= outLast_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/axis_flit_deserializer.md
Name: axis_flit_deserializer

Overview:
Receive-side counterpart of the mesh endpoint serializer. Accepts narrow NoC flits, SERIALIZATION_FACTOR per user beat, from a router ejection port and reassembles them into one full-width AXI-stream beat with tdest/tlast. Detects and recovers from framing errors. Sits between the router ejection port and the user-side axis_out_* interface, with a single clock domain (SINGLE_CLOCK build).

Parameters:
TDATA_WIDTH, 32, width of reassembled user beat
TDEST_WIDTH, 4, width of destination field carried on every flit
SERIALIZATION_FACTOR, 4, flits per beat; must divide TDATA_WIDTH; 1 is legal
(derived, not overridable) FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR

Ports:
clk  in  1  sole clock
rst_n  in  1  synchronous active-low reset
flit_in_tvalid  in  1  flit valid
flit_in_tready  out  1  flit accept
flit_in_tdata  in  FLIT_WIDTH  flit payload, least-significant slice first
flit_in_tdest  in  TDEST_WIDTH  beat destination, repeated on every flit
flit_in_tlast  in  1  beat's packet-last flag, repeated on every flit
flit_in_ttail  in  1  marks final flit of a beat
axis_out_tvalid  out  1  reassembled beat valid
axis_out_tready  in  1  user accept
axis_out_tdata  out  TDATA_WIDTH  reassembled data
axis_out_tdest  out  TDEST_WIDTH  destination captured from flit 0
axis_out_tlast  out  1  tlast captured from flit 0
err_status  out  3  sticky {err_dest, err_long, err_short}; cleared only by reset

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0. Flit index idx=0, state ASSEMBLE, assembly register cleared. A partial beat held at reset is discarded.
- Flit accepted when flit_in_tvalid && flit_in_tready. flit_in_tready is combinational: 1 if state==RESYNC, or idx!=SERIALIZATION_FACTOR-1, or !axis_out_tvalid, or axis_out_tready.
- ASSEMBLE, accepted flit at idx k: write payload to assembly[k*FLIT_WIDTH +: FLIT_WIDTH]. At k=0, capture tdest and tlast. At k>0, a tdest or tlast differing from the captured value sets err_dest; the captured values are kept.
- ttail=1 with k<SERIALIZATION_FACTOR-1: short beat. Partial beat is dropped, err_short set, idx reset to 0, state stays ASSEMBLE.
- k=SERIALIZATION_FACTOR-1 with ttail=1: beat complete. Assembly data (with this flit's slice), captured tdest, and captured tlast load the output register. axis_out_tvalid=1 next cycle (latency 1 cycle from completing flit). idx returns to 0.
- k=SERIALIZATION_FACTOR-1 with ttail=0: long beat. Beat is dropped, err_long set, state goes to RESYNC.
- RESYNC: accept and discard all flits. The first accepted flit with ttail=1 returns the state to ASSEMBLE with idx=0. No output is produced in RESYNC.
- Output register rules:
  - axis_out_* hold stable while tvalid && !tready.
  - tvalid clears on handshake unless a new beat loads in the same cycle. Simultaneous drain and load gives back-to-back beats with no bubble.
  - Sustained throughput is 1 beat per SERIALIZATION_FACTOR cycles.
- SERIALIZATION_FACTOR=1: every flit must carry ttail=1 and is a full beat. ttail=0 enters RESYNC.
- Error bits are OR-accumulated. Multiple errors may be set simultaneously.

Test Plan:
(TDATA_WIDTH=32, TDEST_WIDTH=4, SERIALIZATION_FACTOR=4, FLIT_WIDTH=8, axis_out_tready=1 unless stated.)
1. Basic beat: flits 0x01,0x00,0x00,0x00, tdest=1, tlast=1, ttail on 4th -> one cycle after 4th flit: axis_out_tdata=0x00000001, tdest=1, tlast=1, tvalid for exactly 1 cycle, err_status=0.
2. Backpressure: axis_out_tready=0; stream flits 11,22,33,44 then 55,66,77,88 back-to-back -> first beat holds 0x44332211 stable; flit_in_tready low while 0x88 is presented; raise tready -> 0x44332211 then 0x88776655 on consecutive cycles, nothing lost.
3. Short beat: ttail on idx 1 (flits AA,BB) then valid beat 01..04 -> err_status=3'b001, only output 0x04030201.
4. Long beat: 4 flits without tail, then 2 flits with ttail on the 2nd, then valid beat -> err_status=3'b010, discarded flits produce no output, valid beat emitted correctly.
5. Dest mismatch: beat with tdest=2,2,3,2 -> output tdest=2, data intact, err_status=3'b100.
6. Reset mid-beat: assert rst_n=0 after 2 flits for 1 cycle -> all outputs 0 next cycle; following full beat 0xDEADBEEF emitted correctly, err_status=0.
